reg_exec_ctrl: RTL
==================

Name: reg_exec_ctrl

Overview:
- Initiator-side controller for register_bank.
- Accepts one register-to-register operation at a time over a valid/ready request interface.
- Drives the bank's two read indices, captures operands a/b, computes an 8-bit ALU result, and writes it back through ri_d/d/rw.
- Sits between instruction decode and register_bank; it is the only master of the bank's ports.

Parameters:
- DATA_W, 8, operand/result width; matches bank a/b/d.
- REG_AW, 3, register index width; matches bank ri_a/ri_b/ri_d (8 registers).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, can accept.
- req_op  in  3  operation code (see Behaviour).
- req_rd  in  REG_AW  destination register.
- req_ra  in  REG_AW  source register A.
- req_rb  in  REG_AW  source register B.
- req_imm  in  DATA_W  immediate for LDI.
- done  out  1  one-cycle pulse: operation completes this cycle.
- result  out  DATA_W  last computed result; held until next EXEC.
- flag_z  out  1  last result == 0.
- flag_c  out  1  carry (ADD) / borrow (SUB, CMP); 0 for other ops.
- ri_a  out  REG_AW  bank read index A.
- ri_b  out  REG_AW  bank read index B.
- ri_d  out  REG_AW  bank write index.
- rw  out  1  bank write enable.
- d  out  DATA_W  bank write data.
- a  in  DATA_W  bank read data A.
- b  in  DATA_W  bank read data B.

Behaviour:
- Reset: state IDLE.
  - Latched fields, result, flag_z, flag_c, ri_a, ri_b, ri_d and d = 0.
  - rw = 0, done = 0.
  - req_ready = 1 once rst deasserts.
- States: IDLE -> READ -> EXEC -> WRITE -> IDLE, one cycle each, no stalls.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid=1, latch op/rd/ra/rb/imm and go to READ.
  - req_valid=0 holds IDLE.
  - req_ready is 0 in every other state; requests there are ignored, not queued.
- READ:
  - ri_a = latched ra, ri_b = latched rb; held stable through EXEC.
  - Bank read data is not sampled in READ, so a registered-read bank also works.
- EXEC: sample a/b; compute result per op; update result, flag_z and flag_c at the edge ending EXEC.
- WRITE:
  - ri_d = rd, d = result, rw = 1 except for CMP (rw stays 0).
  - done = 1 for exactly this cycle; the write commits at the edge ending WRITE.
- Latency: accept edge T → done high in cycle T+3. Back-to-back throughput is 1 op per 4 cycles.
- Op encoding: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 MOV a; 6 LDI imm; 7 CMP a-b, flags only.
- LDI still walks READ/EXEC so latency stays fixed.
- Arithmetic: DATA_W-bit wrap-around. flag_c = bit DATA_W of the (DATA_W+1)-bit sum/difference.
  - SUB/CMP: flag_c = 1 iff a < b unsigned.
- rw is high only in WRITE and never for two consecutive cycles.
- Hazards:
  - A write commits before the next READ can start (≥2 cycles gap), so read-after-write needs no forwarding.
  - ra = rb = rd is legal.
- Reset mid-operation: return to IDLE immediately (asynchronous), rw drops in the same instant, no partial write, done not asserted.
- d/ri_d may hold stale values outside WRITE; only rw qualifies them.

Decomposition:
- Shared package reg_exec_pkg holds:
  - op code constants (OP_ADD..OP_CMP);
  - state encoding (ST_IDLE, ST_READ, ST_EXEC, ST_WRITE);
  - default DATA_W/REG_AW.
- One sub-module: reg_exec_alu, combinational.
  - Inputs: op, a, b, imm. Outputs: result, carry.
  - Instantiated in EXEC datapath.
- Bench instantiates reg_exec_ctrl wired to the real register_bank.

Test Plan:
1. Reset asserted mid-WRITE of LDI r2←0x55 → rw falls immediately; afterwards r2 unchanged (0); state IDLE, req_ready=1, done never pulsed.
2. LDI r0←7, LDI r1←5, then ADD r2←r0+r1 → done at accept+3 each time; r2=12, result=12, flag_z=0, flag_c=0.
3. LDI r3←0xF0, LDI r4←0x20, ADD r5←r3+r4 → r5=0x10, flag_c=1. Then SUB r6←r4−r3 → r6=0x30, flag_c=1 (borrow).
4. CMP r0,r0 (r0=7) → result=0, flag_z=1, flag_c=0; rw never asserted; all registers unchanged.
5. Hold req_valid=1 continuously with 3 different ops → accepted exactly at cycles 0, 4, 8; req_ready low otherwise. Include ADD r1←r1+r1 immediately after LDI r1←3 → r1=6 (no hazard).
6. AND/OR/XOR/MOV with r0=0xAA, r1=0x0F → 0x0A, 0xAF, 0xA5, 0xAA into r2..r5; flag_c=0 for each.

Source files
------------

// File: rtl/reg_exec_pkg.sv
// Shared definitions for the register-bank execution controller:
// default widths, opcode values and controller state encoding.
package reg_exec_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/reg_exec_alu.sv
// Combinational ALU for the EXEC step: result plus carry/borrow.
// Carry/borrow is the top bit of the one-bit-wider sum/difference.
module reg_exec_alu #(
  parameter int DATA_W = reg_exec_pkg::DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);
  import reg_exec_pkg::*;

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = w_sum[DATA_W-1:0];
        carry  = w_sum[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        result = w_diff[DATA_W-1:0];
        carry  = w_diff[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      OP_LDI: result = imm;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_exec_ctrl.sv
// Initiator-side controller for register_bank: one op at a time,
// IDLE -> READ -> EXEC -> WRITE, fixed 4-cycle cadence.
module reg_exec_ctrl #(
  parameter int DATA_W = reg_exec_pkg::DATA_W,
  parameter int REG_AW = reg_exec_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [REG_AW-1:0] req_ra,
  input  logic [REG_AW-1:0] req_rb,
  input  logic [DATA_W-1:0] req_imm,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output logic [REG_AW-1:0] ri_a,
  output logic [REG_AW-1:0] ri_b,
  output logic [REG_AW-1:0] ri_d,
  output logic              rw,
  output logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b
);
  import reg_exec_pkg::*;

  state_e              r_state;
  logic [2:0]          r_op;
  logic [REG_AW-1:0]   r_rd;
  logic [DATA_W-1:0]   r_imm;
  logic [REG_AW-1:0]   r_ri_a;
  logic [REG_AW-1:0]   r_ri_b;
  logic [REG_AW-1:0]   r_ri_d;
  logic [DATA_W-1:0]   r_d;
  logic                r_rw;
  logic                r_done;
  logic [DATA_W-1:0]   r_result;
  logic                r_flag_z;
  logic                r_flag_c;

  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_carry;

  reg_exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (r_op),
    .a      (a),
    .b      (b),
    .imm    (r_imm),
    .result (w_alu_result),
    .carry  (w_alu_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_ri_a   <= '0;
      r_ri_b   <= '0;
      r_ri_d   <= '0;
      r_d      <= '0;
      r_rw     <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      r_rw   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_rd    <= req_rd;
            r_imm   <= req_imm;
            r_ri_a  <= req_ra;
            r_ri_b  <= req_rb;
            r_state <= ST_READ;
          end
        end
        // Read indices settle here; operands are sampled only at the end of EXEC.
        ST_READ: r_state <= ST_EXEC;
        ST_EXEC: begin
          r_result <= w_alu_result;
          r_flag_z <= (w_alu_result == '0);
          r_flag_c <= w_alu_carry;
          r_ri_d   <= r_rd;
          r_d      <= w_alu_result;
          r_rw     <= (r_op != OP_CMP);
          r_done   <= 1'b1;
          r_state  <= ST_WRITE;
        end
        ST_WRITE: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign flag_z    = r_flag_z;
  assign flag_c    = r_flag_c;
  assign ri_a      = r_ri_a;
  assign ri_b      = r_ri_b;
  assign ri_d      = r_ri_d;
  assign rw        = r_rw;
  assign d         = r_d;

endmodule
